// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine popping a FIFO into a 2-entry
// registered valid/ready output buffer, with a delivered-word counter.
// Ports: rclk/rrst_n clock and async active-low reset; rempty/rdata/rinc
// FIFO read port; ren drain enable; flush discards buffered words;
// m_valid/m_data/m_ready output stream; occ occupancy; pop_count delivered.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             ren,
  input  logic             flush,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occ,
  output logic [CNTW-1:0]  pop_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;
  logic [DSIZE-1:0] buf0_nx;
  logic [DSIZE-1:0] buf1_nx;
  logic             valid_q;
  logic             deq;

  assign m_valid = valid_q;
  assign m_data  = buf0;
  assign occ     = state;
  assign deq     = valid_q & m_ready;

  // In TWO a pop is only safe when the head leaves in the same cycle.
  assign rinc = rrst_n & ren & ~rempty & ~flush
              & ((state != TWO) | m_ready);

  always_comb begin
    state_nx = state;
    buf0_nx  = buf0;
    buf1_nx  = buf1;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (rinc) begin
            buf0_nx  = rdata;
            state_nx = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            (rinc & ~deq): begin
              buf1_nx  = rdata;
              state_nx = TWO;
            end
            (rinc & deq): begin
              buf0_nx = rdata;
            end
            (~rinc & deq): begin
              state_nx = EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (deq) begin
            buf0_nx = buf1;
            if (rinc) begin
              buf1_nx = rdata;
            end else begin
              state_nx = ONE;
            end
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= EMPTY;
      buf0    <= '0;
      buf1    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      buf0    <= buf0_nx;
      buf1    <= buf1_nx;
      valid_q <= (state_nx != EMPTY);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_count <= '0;
    end else if (deq) begin
      pop_count <= pop_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream with a FIFO model,
// an expected-word scoreboard and a monitor that checks delivered words.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       ren;
  logic       flush;
  logic       m_ready;

  logic        rinc;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  occ;
  logic [15:0] pop_count;

  logic        rinc4;
  logic        m_valid4;
  logic [7:0]  m_data4;
  logic [1:0]  occ4;
  logic [3:0]  pop_count4;

  int checks = 0;
  int failures = 0;
  int rinc_cnt = 0;
  int r0;

  logic [7:0] fq[$];
  logic [7:0] exq[$];

  fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(clk), .rrst_n(rst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .ren(ren), .flush(flush), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .occ(occ),
    .pop_count(pop_count)
  );

  fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
    .rclk(clk), .rrst_n(rst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc4), .ren(ren), .flush(flush), .m_valid(m_valid4),
    .m_data(m_data4), .m_ready(m_ready), .occ(occ4),
    .pop_count(pop_count4)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic [7:0] d, bit keep);
    fq.push_back(d);
    if (keep) exq.push_back(d);
    refresh();
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: samples before each rising edge, checks deliveries against
  // the scoreboard, then retires FIFO words the DUT popped at that edge.
  always begin : mon
    logic       s;
    logic [7:0] e;
    @(negedge clk);
    #4;
    s = rinc;
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exq.size() == 0) begin
        failures++;
        $display("FAIL stream: got %0h expected no word", m_data);
      end else begin
        e = exq.pop_front();
        if (m_data !== e || m_valid4 !== 1'b1 || m_data4 !== e) begin
          failures++;
          $display("FAIL stream: got %0h/%0h expected %0h",
                   m_data, m_data4, e);
        end
      end
    end
    if (s) rinc_cnt++;
    @(posedge clk);
    #1;
    if (s) begin
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL pop_empty: got rinc 1 expected 0");
      end else begin
        void'(fq.pop_front());
      end
      refresh();
    end
  end

  initial begin
    rst_n   = 1'b0;
    ren     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    refresh();
    push(8'hA5, 1'b0);

    cyc(2);
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_cnt", pop_count, 0);
    rst_n = 1'b1;
    #1;
    chk("first_rinc", rinc, 1);
    cyc(1);
    chk("first_occ", occ, 1);
    chk("first_valid", m_valid, 1);
    chk("first_data", m_data, 8'hA5);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t1_flush_occ", occ, 0);
    chk("t1_flush_valid", m_valid, 0);
    chk("t1_cnt", pop_count, 0);

    m_ready = 1'b1;
    r0 = rinc_cnt;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    cyc(1);
    chk("lat_valid", m_valid, 1);
    chk("lat_data", m_data, 8'h01);
    cyc(15);
    chk("cnt_15", pop_count, 15);
    chk("cnt4_15", pop_count4, 15);
    cyc(1);
    chk("cnt_16", pop_count, 16);
    chk("cnt4_wrap", pop_count4, 0);
    cyc(1);
    chk("t2_rincs", rinc_cnt - r0, 16);
    chk("t2_occ", occ, 0);

    m_ready = 1'b0;
    r0 = rinc_cnt;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    cyc(3);
    chk("stall_occ", occ, 2);
    chk("stall_occ4", occ4, 2);
    chk("stall_data", m_data, 8'h11);
    chk("stall_rinc", rinc, 0);
    chk("stall_rinc4", rinc4, 0);
    chk("stall_pops", rinc_cnt - r0, 2);
    chk("stall_fq", fq.size(), 1);
    m_ready = 1'b1;
    cyc(1);
    chk("cnt_17", pop_count, 17);
    chk("cnt4_17", pop_count4, 1);
    cyc(3);
    chk("t3_occ", occ, 0);
    chk("t3_fq", fq.size(), 0);

    m_ready = 1'b0;
    push(8'h44, 1'b1);
    push(8'h55, 1'b0);
    push(8'h66, 1'b1);
    cyc(3);
    chk("pre_flush_occ", occ, 2);
    chk("pre_flush_data", m_data, 8'h44);
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("flush_rinc", rinc, 0);
    cyc(1);
    flush = 1'b0;
    chk("flush_occ", occ, 0);
    chk("flush_valid", m_valid, 0);
    chk("flush_fq", fq.size(), 1);
    cyc(3);
    chk("t4_cnt", pop_count, 21);
    chk("t4_cnt4", pop_count4, 5);
    chk("t4_occ", occ, 0);
    chk("t4_fq", fq.size(), 0);

    m_ready = 1'b0;
    push(8'h77, 1'b1);
    push(8'h88, 1'b1);
    push(8'h99, 1'b1);
    cyc(3);
    chk("ren_pre_occ", occ, 2);
    ren     = 1'b0;
    m_ready = 1'b1;
    r0 = rinc_cnt;
    cyc(1);
    chk("ren_occ1", occ, 1);
    chk("ren_data", m_data, 8'h88);
    cyc(1);
    chk("ren_occ0", occ, 0);
    chk("ren_valid", m_valid, 0);
    chk("ren_rinc", rinc, 0);
    chk("ren_pops", rinc_cnt - r0, 0);
    chk("ren_fq", fq.size(), 1);
    ren = 1'b1;
    cyc(3);
    chk("t6_occ", occ, 0);
    chk("t6_cnt", pop_count, 24);
    chk("t6_cnt4", pop_count4, 8);
    chk("t6_fq", fq.size(), 0);
    chk("exq_empty", exq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
